// File: rtl/bsg_circular_ring_alloc_if.sv
// Handshake bundle for the circular ring slot allocator.
//
// Producer side : alloc_v_i / alloc_n_i in, alloc_ready_o / alloc_base_o out.
// Consumer side : free_v_i / free_n_i in, free_base_o out.
// Status        : count_o, empty_o, full_o, error_o.
//
// Modports:
//   master - the requester (drives the alloc/free requests, observes status)
//   slave  - the allocator itself
interface bsg_circular_ring_alloc_if #(
  parameter int slots_p   = 32,
  parameter int max_add_p = 5
);
  localparam int ptr_width_lp = $clog2(slots_p);
  localparam int cnt_width_lp = $clog2(slots_p + 1);
  localparam int n_width_lp   = $clog2(max_add_p + 1);

  logic                    alloc_v_i;
  logic [n_width_lp-1:0]   alloc_n_i;
  logic                    alloc_ready_o;
  logic [ptr_width_lp-1:0] alloc_base_o;
  logic                    free_v_i;
  logic [n_width_lp-1:0]   free_n_i;
  logic [ptr_width_lp-1:0] free_base_o;
  logic [cnt_width_lp-1:0] count_o;
  logic                    empty_o;
  logic                    full_o;
  logic                    error_o;

  modport master (
    output alloc_v_i, alloc_n_i, free_v_i, free_n_i,
    input  alloc_ready_o, alloc_base_o, free_base_o,
           count_o, empty_o, full_o, error_o
  );

  modport slave (
    input  alloc_v_i, alloc_n_i, free_v_i, free_n_i,
    output alloc_ready_o, alloc_base_o, free_base_o,
           count_o, empty_o, full_o, error_o
  );
endinterface

// File: rtl/bsg_circular_ring_alloc.sv
// Circular ring slot allocator.
//
// Tracks a ring of slots_p entries with a write (allocate) pointer, a read
// (free) pointer and an occupancy count. Each cycle a producer may claim up to
// max_add_p contiguous slots and a consumer may release up to max_add_p of the
// oldest slots. Grant and base are combinational in the request cycle; pointer
// and count updates appear on the next cycle.
//
// Ports:
//   clk     - clock
//   reset_i - synchronous active-high reset
//   ring    - slave side of bsg_circular_ring_alloc_if (requests and status)
module bsg_circular_ring_alloc #(
  parameter int slots_p   = 32,
  parameter int max_add_p = 5
) (
  input  logic                          clk,
  input  logic                          reset_i,
  bsg_circular_ring_alloc_if.slave      ring
);
  localparam int ptr_width_lp = $clog2(slots_p);
  localparam int cnt_width_lp = $clog2(slots_p + 1);
  localparam int n_width_lp   = $clog2(max_add_p + 1);

  localparam logic [cnt_width_lp-1:0] slots_cnt_lp = cnt_width_lp'(slots_p);
  localparam logic [ptr_width_lp:0]   slots_sum_lp = (ptr_width_lp + 1)'(slots_p);
  localparam logic [n_width_lp-1:0]   max_n_lp     = n_width_lp'(max_add_p);

  logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
  logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
  logic [cnt_width_lp-1:0] count_reg, count_next;
  logic                    error_reg, error_next;

  logic [cnt_width_lp-1:0] space;
  logic [cnt_width_lp-1:0] alloc_n_cnt;
  logic [cnt_width_lp-1:0] free_n_cnt;
  logic                    alloc_ready;
  logic                    alloc_n_ok;
  logic                    free_n_ok;
  logic                    alloc_fire;
  logic                    free_fire;

  // Modular add for a pointer that need not span a power of two. ptr < slots_p
  // and n < slots_p, so one conditional subtract brings the sum back in range.
  function automatic logic [ptr_width_lp-1:0] ring_add(
    input logic [ptr_width_lp-1:0] ptr,
    input logic [n_width_lp-1:0]   n
  );
    logic [ptr_width_lp:0] sum;
    sum = {1'b0, ptr} + (ptr_width_lp + 1)'(n);
    if (sum >= slots_sum_lp) begin
      sum = sum - slots_sum_lp;
    end
    return sum[ptr_width_lp-1:0];
  endfunction

  always_comb begin
    space       = slots_cnt_lp - count_reg;
    alloc_n_cnt = cnt_width_lp'(ring.alloc_n_i);
    free_n_cnt  = cnt_width_lp'(ring.free_n_i);

    // Space is judged on the registered count only: a free in this cycle
    // does not make room until the next one.
    alloc_ready = (space >= alloc_n_cnt);
    alloc_n_ok  = (ring.alloc_n_i <= max_n_lp);
    free_n_ok   = (free_n_cnt <= count_reg) && (ring.free_n_i <= max_n_lp);

    alloc_fire  = ring.alloc_v_i & alloc_ready & alloc_n_ok;
    free_fire   = ring.free_v_i & free_n_ok;

    wptr_next   = alloc_fire ? ring_add(wptr_reg, ring.alloc_n_i) : wptr_reg;
    rptr_next   = free_fire  ? ring_add(rptr_reg, ring.free_n_i)  : rptr_reg;
    count_next  = count_reg
                + (alloc_fire ? alloc_n_cnt : '0)
                - (free_fire  ? free_n_cnt  : '0);

    // A not-ready allocate is just back-pressure; only malformed sizes or an
    // over-release are protocol errors.
    error_next  = error_reg
                | (ring.alloc_v_i & ~alloc_n_ok)
                | (ring.free_v_i  & ~free_n_ok);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  // Pointers coincide both when full and when empty, so status comes from
  // the count alone.
  assign ring.alloc_ready_o = alloc_ready;
  assign ring.alloc_base_o  = wptr_reg;
  assign ring.free_base_o   = rptr_reg;
  assign ring.count_o       = count_reg;
  assign ring.empty_o       = (count_reg == '0);
  assign ring.full_o        = (count_reg == slots_cnt_lp);
  assign ring.error_o       = error_reg;
endmodule

// File: tb/tb_bsg_circular_ring_alloc.sv
module tb_bsg_circular_ring_alloc;
  logic clk = 1'b0;
  logic reset_i;

  always #5 clk = ~clk;

  bsg_circular_ring_alloc_if #(.slots_p(32), .max_add_p(5)) ifa ();
  bsg_circular_ring_alloc_if #(.slots_p(5),  .max_add_p(3)) ifb ();

  bsg_circular_ring_alloc #(.slots_p(32), .max_add_p(5)) dut_a (
    .clk     (clk),
    .reset_i (reset_i),
    .ring    (ifa)
  );

  bsg_circular_ring_alloc #(.slots_p(5), .max_add_p(3)) dut_b (
    .clk     (clk),
    .reset_i (reset_i),
    .ring    (ifb)
  );

  typedef struct {
    int    dut;
    string name;
    int    ready;
    int    abase;
    int    fbase;
    int    count;
    int    empty;
    int    full;
    int    err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  // Monitor: every negedge with a pending expectation, sample the DUT and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   r, ab, fb, c, em, fu, er;
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        r = int'(ifa.alloc_ready_o); ab = int'(ifa.alloc_base_o); fb = int'(ifa.free_base_o);
        c = int'(ifa.count_o); em = int'(ifa.empty_o); fu = int'(ifa.full_o); er = int'(ifa.error_o);
      end else begin
        r = int'(ifb.alloc_ready_o); ab = int'(ifb.alloc_base_o); fb = int'(ifb.free_base_o);
        c = int'(ifb.count_o); em = int'(ifb.empty_o); fu = int'(ifb.full_o); er = int'(ifb.error_o);
      end
      check(e.name, "ready", r,  e.ready);
      check(e.name, "abase", ab, e.abase);
      check(e.name, "fbase", fb, e.fbase);
      check(e.name, "count", c,  e.count);
      check(e.name, "empty", em, e.empty);
      check(e.name, "full",  fu, e.full);
      check(e.name, "error", er, e.err);
      $display("txn dut=%0d %-14s ready=%0d abase=%0d fbase=%0d count=%0d empty=%0d full=%0d error=%0d",
               e.dut, e.name, r, ab, fb, c, em, fu, er);
    end
  end

  // Drive one cycle of stimulus and queue the hand-computed view of that cycle
  // (combinational grant/base plus the registered state before the edge).
  task automatic step(input int d, input string nm, input logic rst,
                      input logic av, input int an, input logic fv, input int fn,
                      input int er, input int eab, input int efb, input int ec, input int ee);
    exp_t e;
    reset_i = rst;
    if (d == 0) begin
      ifa.alloc_v_i = av; ifa.alloc_n_i = 3'(an);
      ifa.free_v_i  = fv; ifa.free_n_i  = 3'(fn);
    end else begin
      ifb.alloc_v_i = av; ifb.alloc_n_i = 2'(an);
      ifb.free_v_i  = fv; ifb.free_n_i  = 2'(fn);
    end
    e.dut = d; e.name = nm; e.ready = er; e.abase = eab; e.fbase = efb;
    e.count = ec; e.err = ee;
    e.empty = (ec == 0) ? 1 : 0;
    e.full  = (ec == ((d == 0) ? 32 : 5)) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    ifa.alloc_v_i = 1'b0; ifa.alloc_n_i = '0; ifa.free_v_i = 1'b0; ifa.free_n_i = '0;
    ifb.alloc_v_i = 1'b0; ifb.alloc_n_i = '0; ifb.free_v_i = 1'b0; ifb.free_n_i = '0;
    repeat (2) @(posedge clk);
    #1;

    //   dut name              rst av an fv fn  rdy ab fb cnt err
    step(0, "reset_idle",     0, 0, 5, 0, 0,  1,  0, 0, 0,  0);
    for (int i = 0; i < 6; i++)
      step(0, "alloc5",       0, 1, 5, 0, 0,  1, 5*i, 0, 5*i, 0);
    step(0, "alloc5_block",   0, 1, 5, 0, 0,  0, 30, 0, 30, 0);
    step(0, "alloc2_fill",    0, 1, 2, 0, 0,  1, 30, 0, 30, 0);
    step(0, "full",           0, 0, 0, 0, 0,  1,  0, 0, 32, 0);
    step(0, "reset_mid",      1, 1, 5, 0, 0,  0,  0, 0, 32, 0);
    step(0, "after_reset",    0, 0, 0, 0, 0,  1,  0, 0, 0,  0);
    for (int i = 0; i < 6; i++)
      step(0, "refill5",      0, 1, 5, 0, 0,  1, 5*i, 0, 5*i, 0);
    step(0, "alloc4_free5",   0, 1, 4, 1, 5,  0, 30, 0, 30, 0);
    step(0, "alloc4_wrap",    0, 1, 4, 0, 0,  1, 30, 5, 25, 0);
    step(0, "wrap_free5",     0, 0, 0, 1, 5,  1,  2, 5, 29, 0);
    step(0, "free5",          0, 0, 0, 1, 5,  1,  2, 10, 24, 0);
    step(0, "free5",          0, 0, 0, 1, 5,  1,  2, 15, 19, 0);
    step(0, "free5",          0, 0, 0, 1, 5,  1,  2, 20, 14, 0);
    step(0, "free5",          0, 0, 0, 1, 5,  1,  2, 25, 9,  0);
    step(0, "free2",          0, 0, 0, 1, 2,  1,  2, 30, 4,  0);
    step(0, "free3_over",     0, 0, 0, 1, 3,  1,  2, 0, 2,  0);
    step(0, "err_set",        0, 0, 0, 0, 0,  1,  2, 0, 2,  1);
    step(0, "err_sticky",     0, 0, 0, 0, 0,  1,  2, 0, 2,  1);
    step(0, "reset_err",      1, 0, 0, 0, 0,  1,  2, 0, 2,  1);
    step(0, "alloc6_over",    0, 1, 6, 0, 0,  1,  0, 0, 0,  0);
    step(0, "alloc_err_set",  0, 0, 0, 0, 0,  1,  0, 0, 0,  1);
    step(0, "reset_err2",     1, 0, 0, 0, 0,  1,  0, 0, 0,  1);
    step(0, "alloc3",         0, 1, 3, 0, 0,  1,  0, 0, 0,  0);
    step(0, "noop",           0, 1, 0, 1, 0,  1,  3, 0, 3,  0);
    step(0, "noop_hold",      0, 1, 5, 0, 0,  1,  3, 0, 3,  0);
    step(0, "free6_over",     0, 0, 0, 1, 6,  1,  8, 0, 8,  0);
    step(0, "free_max_err",   0, 0, 0, 0, 0,  1,  8, 0, 8,  1);

    // Non-power-of-two ring: 5 slots, up to 3 per cycle.
    step(1, "b_alloc3",       0, 1, 3, 0, 0,  1,  0, 0, 0,  0);
    step(1, "b_free3",        0, 0, 0, 1, 3,  1,  3, 0, 3,  0);
    step(1, "b_alloc3_wrap",  0, 1, 3, 0, 0,  1,  3, 3, 0,  0);
    step(1, "b_final",        0, 0, 0, 0, 0,  1,  1, 3, 3,  0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
